// File: rtl/pipeline_swap_sequencer.sv
// pipeline_swap_sequencer
//   Sequences a glitch-free swap between the active and standby DSP pipelines.
//   A request crossfades the mixer gains over fade_samples sample ticks. The
//   sequencer then flips current_pipeline, pulses a reset into the retired
//   pipeline, and waits until that pipeline reports its reset is complete.
// Ports
//   clk, reset          : system clock, asynchronous active-high reset
//   swap_req            : 1-cycle swap request
//   sample_tick         : 1-cycle strobe per processed sample
//   pipeline_resetting  : per-pipeline "reset in progress" flags
//   current_pipeline    : index of the audible pipeline
//   pipelines_swapping  : high from request acceptance until swap_done
//   gain_cur/gain_next  : mixer gains for current / standby pipeline (Q1.x)
//   pipeline_reset      : 1-cycle reset pulse per pipeline
//   swap_done           : 1-cycle pulse at swap completion
//   swap_rejected       : 1-cycle pulse for a request that arrives while busy
module pipeline_swap_sequencer #(
  parameter int gain_width   = 16,
  parameter int fade_samples = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  swap_req,
  input  logic                  sample_tick,
  input  logic [1:0]            pipeline_resetting,
  output logic                  current_pipeline,
  output logic                  pipelines_swapping,
  output logic [gain_width-1:0] gain_cur,
  output logic [gain_width-1:0] gain_next,
  output logic [1:0]            pipeline_reset,
  output logic                  swap_done,
  output logic                  swap_rejected
);

  localparam int CW    = $clog2(fade_samples) + 1;
  localparam int SHIFT = gain_width - 1 - $clog2(fade_samples);
  localparam logic [gain_width-1:0] FULL = {1'b1, {(gain_width-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_TGT = 3'd1,
    FADING   = 3'd2,
    FLIP     = 3'd3,
    CLEAR    = 3'd4
  } state_t;

  state_t                state_r, state_nxt_s;
  logic [CW-1:0]         cnt_r, cnt_nxt_s, cnt_inc_s;
  logic                  clr_first_r, clr_first_nxt_s;
  logic                  cur_nxt_s, swapping_nxt_s, done_nxt_s, rej_nxt_s;
  logic [gain_width-1:0] gain_cur_nxt_s, gain_next_nxt_s, gain_step_s;
  logic [1:0]            preset_nxt_s;
  logic                  busy_s;
  logic                  tgt_busy_s;
  logic                  old_busy_s;

  // Fade arithmetic: next count and the standby gain that count maps to.
  always_comb begin
    cnt_inc_s   = cnt_r + CW'(1);
    gain_step_s = gain_width'(cnt_inc_s) << SHIFT;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt_s     = state_r;
    cnt_nxt_s       = cnt_r;
    clr_first_nxt_s = clr_first_r;
    cur_nxt_s       = current_pipeline;
    swapping_nxt_s  = pipelines_swapping;
    gain_cur_nxt_s  = gain_cur;
    gain_next_nxt_s = gain_next;
    preset_nxt_s    = 2'b00;
    done_nxt_s      = 1'b0;
    rej_nxt_s       = 1'b0;
    // Both the incoming pipeline (before the flip) and the retired pipeline
    // (after the flip) are the one not currently audible.
    tgt_busy_s      = pipeline_resetting[~current_pipeline];
    old_busy_s      = pipeline_resetting[~current_pipeline];
    // The swap_done cycle still counts as part of the swap, so a request
    // landing on it is rejected rather than starting a new swap.
    busy_s          = (state_r != IDLE) || swap_done;

    if (swap_req && busy_s) begin
      rej_nxt_s = 1'b1;
    end else begin
      rej_nxt_s = 1'b0;
    end

    case (state_r)
      IDLE: begin
        if (swap_req && !busy_s) begin
          swapping_nxt_s = 1'b1;
          cnt_nxt_s      = '0;
          state_nxt_s    = tgt_busy_s ? WAIT_TGT : FADING;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT_TGT: begin
        if (!tgt_busy_s) begin
          state_nxt_s = FADING;
        end else begin
          state_nxt_s = WAIT_TGT;
        end
      end
      FADING: begin
        if (sample_tick) begin
          cnt_nxt_s       = cnt_inc_s;
          gain_next_nxt_s = gain_step_s;
          gain_cur_nxt_s  = FULL - gain_step_s;
          if (cnt_inc_s == CW'(fade_samples)) begin
            state_nxt_s = FLIP;
          end else begin
            state_nxt_s = FADING;
          end
        end else begin
          state_nxt_s = FADING;
        end
      end
      FLIP: begin
        // Standby was at FULL, so after the flip the new current pipeline
        // keeps FULL and the audible output is continuous.
        cur_nxt_s       = ~current_pipeline;
        gain_cur_nxt_s  = FULL;
        gain_next_nxt_s = '0;
        preset_nxt_s    = current_pipeline ? 2'b10 : 2'b01;
        clr_first_nxt_s = 1'b1;
        state_nxt_s     = CLEAR;
      end
      CLEAR: begin
        // The first CLEAR cycle is unconditional so that a resetting flag
        // raised one cycle after the pulse is still seen.
        if (clr_first_r) begin
          clr_first_nxt_s = 1'b0;
        end else if (!old_busy_s) begin
          done_nxt_s     = 1'b1;
          swapping_nxt_s = 1'b0;
          state_nxt_s    = IDLE;
        end else begin
          state_nxt_s = CLEAR;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r            <= IDLE;
      cnt_r              <= '0;
      clr_first_r        <= 1'b0;
      current_pipeline   <= 1'b0;
      pipelines_swapping <= 1'b0;
      gain_cur           <= FULL;
      gain_next          <= '0;
      pipeline_reset     <= 2'b00;
      swap_done          <= 1'b0;
      swap_rejected      <= 1'b0;
    end else begin
      state_r            <= state_nxt_s;
      cnt_r              <= cnt_nxt_s;
      clr_first_r        <= clr_first_nxt_s;
      current_pipeline   <= cur_nxt_s;
      pipelines_swapping <= swapping_nxt_s;
      gain_cur           <= gain_cur_nxt_s;
      gain_next          <= gain_next_nxt_s;
      pipeline_reset     <= preset_nxt_s;
      swap_done          <= done_nxt_s;
      swap_rejected      <= rej_nxt_s;
    end
  end

endmodule

// File: tb/tb_pipeline_swap_sequencer.sv
// Testbench for pipeline_swap_sequencer (gain_width=16, fade_samples=4).
// Expected gains are k*STEP after the k-th counted tick; the expected audible
// pipeline toggles once per completed swap.
module tb_pipeline_swap_sequencer;

  localparam int GW   = 16;
  localparam int FS   = 4;
  localparam int FULL = 32768;
  localparam int STEP = FULL / FS;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          swap_req = 1'b0;
  logic          sample_tick = 1'b0;
  logic [1:0]    pipeline_resetting = 2'b00;
  logic          current_pipeline;
  logic          pipelines_swapping;
  logic [GW-1:0] gain_cur;
  logic [GW-1:0] gain_next;
  logic [1:0]    pipeline_reset;
  logic          swap_done;
  logic          swap_rejected;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int swaps = 0;
  bit exp_cur = 1'b0;

  pipeline_swap_sequencer #(.gain_width(GW), .fade_samples(FS)) dut (
    .clk(clk), .reset(reset), .swap_req(swap_req), .sample_tick(sample_tick),
    .pipeline_resetting(pipeline_resetting), .current_pipeline(current_pipeline),
    .pipelines_swapping(pipelines_swapping), .gain_cur(gain_cur), .gain_next(gain_next),
    .pipeline_reset(pipeline_reset), .swap_done(swap_done), .swap_rejected(swap_rejected)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic tick();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
  endtask

  // Per-cycle invariants: gains always sum to FULL; reset never hits the
  // audible pipeline; at most one reset pulse at a time.
  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      assert (({1'b0, gain_cur} + {1'b0, gain_next}) === 17'(FULL)) else begin
        errors++;
        $error("FAIL gain_sum observed=%0d expected=%0d", gain_cur + gain_next, FULL);
      end
      checks++;
      assert ((pipeline_reset & (current_pipeline ? 2'b10 : 2'b01)) === 2'b00 &&
              pipeline_reset !== 2'b11) else begin
        errors++;
        $error("FAIL reset_active observed=%b expected=not-active cur=%0d", pipeline_reset, current_pipeline);
      end
      if (swap_done) done_cnt++;
    end
  end

  // One complete swap. busy: incoming pipeline resetting at request time;
  // rej: fire rejected requests during FADING, CLEAR and on swap_done;
  // simul: request together with a tick; hold: cycles the retired pipeline
  // reports resetting after the flip.
  task automatic do_swap(input bit busy, input bit rej, input bit simul, input int hold);
    int tgt_i;
    int old_i;
    int g;
    tgt_i = exp_cur ? 0 : 1;
    old_i = exp_cur ? 1 : 0;
    if (busy) pipeline_resetting[tgt_i] = 1'b1;
    swap_req = 1'b1;
    sample_tick = simul;
    step();
    swap_req = 1'b0;
    sample_tick = 1'b0;
    chk("accept_swapping", pipelines_swapping, 1);
    chk("accept_gain_next", gain_next, 0);
    if (busy) begin
      g = $urandom_range(2, 6);
      for (int i = 0; i < g; i++) begin
        tick();
        chk("wait_tgt_gain_next", gain_next, 0);
        chk("wait_tgt_gain_cur", gain_cur, FULL);
      end
      pipeline_resetting[tgt_i] = 1'b0;
      step();
      chk("wait_tgt_exit_gain", gain_next, 0);
    end
    for (int k = 1; k <= FS; k++) begin
      if (k > 1) begin
        idle($urandom_range(0, 8));
        chk("gap_gain_next", gain_next, (k - 1) * STEP);
      end
      tick();
      chk("fade_gain_next", gain_next, k * STEP);
      chk("fade_gain_cur", gain_cur, FULL - k * STEP);
      chk("fade_cur", current_pipeline, exp_cur);
      if (rej && k == 2) begin
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        chk("rej_fading", swap_rejected, 1);
        chk("rej_fading_gain", gain_next, 2 * STEP);
      end
    end
    step();
    exp_cur = ~exp_cur;
    swaps++;
    chk("flip_cur", current_pipeline, exp_cur);
    chk("flip_gain_cur", gain_cur, FULL);
    chk("flip_gain_next", gain_next, 0);
    chk("flip_reset_pulse", pipeline_reset, (old_i == 1) ? 2'b10 : 2'b01);
    if (hold > 0) begin
      pipeline_resetting[old_i] = 1'b1;
      if (rej) swap_req = 1'b1;
      step();
      swap_req = 1'b0;
      chk("reset_pulse_width", pipeline_reset, 0);
      if (rej) chk("rej_clear", swap_rejected, 1);
      for (int i = 1; i < hold; i++) step();
      chk("hold_swapping", pipelines_swapping, 1);
      chk("hold_done", swap_done, 0);
      pipeline_resetting[old_i] = 1'b0;
      step();
    end else begin
      step();
      chk("reset_pulse_width", pipeline_reset, 0);
      chk("clear_min_done", swap_done, 0);
      step();
    end
    chk("swap_done", swap_done, 1);
    chk("done_swapping", pipelines_swapping, 0);
    chk("done_cur", current_pipeline, exp_cur);
    if (rej) swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    chk("done_pulse_width", swap_done, 0);
    if (rej) begin
      chk("rej_on_done", swap_rejected, 1);
      chk("rej_on_done_idle", pipelines_swapping, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(2);
    reset = 1'b0;
    chk("rst_cur", current_pipeline, 0);
    chk("rst_gain_cur", gain_cur, FULL);
    chk("rst_gain_next", gain_next, 0);
    chk("rst_swapping", pipelines_swapping, 0);
    chk("rst_preset", pipeline_reset, 0);
    chk("rst_done", swap_done, 0);
    chk("rst_rej", swap_rejected, 0);

    // Basic swap 0 -> 1.
    do_swap(1'b0, 1'b0, 1'b0, 0);

    // Async reset after the second tick, asserted mid-cycle.
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    tick();
    idle(2);
    tick();
    chk("pre_reset_gain", gain_next, 2 * STEP);
    #2;
    reset = 1'b1;
    #1;
    chk("async_cur", current_pipeline, 0);
    chk("async_gain_cur", gain_cur, FULL);
    chk("async_gain_next", gain_next, 0);
    chk("async_swapping", pipelines_swapping, 0);
    chk("async_preset", pipeline_reset, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_cur = 1'b0;
    step();
    chk("post_reset_gain", gain_next, 0);
    do_swap(1'b0, 1'b0, 1'b0, 0);

    // Target busy, busy rejects, slow old reset.
    do_swap(1'b1, 1'b0, 1'b0, 0);
    do_swap(1'b0, 1'b1, 1'b0, 3);
    do_swap(1'b0, 1'b0, 1'b0, 50);

    // Request with a simultaneous tick, twice, starting from pipeline 0.
    chk("simul_start_cur", current_pipeline, 0);
    do_swap(1'b0, 1'b0, 1'b1, 0);
    do_swap(1'b0, 1'b0, 1'b1, 1);
    chk("simul_end_cur", current_pipeline, 0);

    // Randomized swaps.
    for (int r = 0; r < 4; r++) begin
      do_swap(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), $urandom_range(0, 5));
    end

    idle(2);
    chk("done_count", done_cnt, swaps);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
